mem_access: RTL

Memory-access stage that consumes the executer's outputs and acts as the initiator on the data-memory bus. It issues byte, halfword and word loads and stores with a request/acknowledge handshake. It aligns and extends load data, then presents a one-cycle register-writeback beat. ALU-only results pass straight through to writeback.

---
 rtl/mspu_mem_pkg.sv | 51 +++++
 rtl/load_align.sv | 28 ++
 rtl/mem_access.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mspu_mem_pkg.sv
// Shared types and lane helpers for the memory-access stage: size encoding,
// FSM states, byte-enable / store-replication / load-offset functions.
package mspu_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  // Encoding 3 is folded onto a word access.
  function automatic size_e decode_size(input logic [1:0] bytes);
    case (bytes)
      2'd0:    return SIZE_BYTE;
      2'd1:    return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  // Effective byte offset inside the word; bits finer than the access size are dropped.
  function automatic logic [1:0] lane_offset(input size_e size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return a;
      SIZE_HALF: return {a[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return 4'b0001 << a;
      SIZE_HALF: return 4'b0011 << {a[1], 1'b0};
      default:   return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input size_e size, input logic [31:0] d);
    case (size)
      SIZE_BYTE: return {4{d[7:0]}};
      SIZE_HALF: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shifts the addressed lane down to bit 0 and
// sign- or zero-extends bytes and halfwords to 32 bits.
module load_align
  import mspu_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SIZE_BYTE: data = load_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = load_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: data-bus initiator with req/ack handshake and a one-cycle
// writeback beat. Optional MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access
  import mspu_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] alu_result,
  input  logic        mem_to_reg,
  input  logic [1:0]  bytes,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  rd,
  input  logic        reg_we,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        busy,
  output logic        misalign_err
);

  state_e      state, state_nxt;
  size_e       in_size;
  logic        mem_op, trap;

  // Operands captured at acceptance so the executer may move on during the access.
  logic [31:0] op_addr, op_addr_nxt;
  size_e       op_size, op_size_nxt;
  logic        op_uns, op_uns_nxt, op_m2r, op_m2r_nxt, op_reg_we, op_reg_we_nxt;
  logic [4:0]  op_rd, op_rd_nxt;

  logic        req_nxt, dwe_nxt, wb_we_nxt, done_nxt, mis_nxt, mis_q;
  logic [31:0] addr_nxt, dwdata_nxt, wb_data_nxt, load_data;
  logic [3:0]  be_nxt;
  logic [4:0]  wb_rd_nxt;
  logic [1:0]  ld_offset;

  assign in_size = decode_size(bytes);
  assign mem_op  = we | re;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = mem_op && (((in_size == SIZE_HALF) && alu_result[0]) ||
                           ((in_size == SIZE_WORD) && (alu_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign busy         = (state != ST_IDLE);
  assign misalign_err = mis_q;
  assign ld_offset    = lane_offset(op_size, op_addr[1:0]);

  load_align u_load_align (
    .rdata         (dmem_rdata),
    .size          (op_size),
    .offset        (ld_offset),
    .load_unsigned (op_uns),
    .data          (load_data)
  );

  always_comb begin
    state_nxt     = state;
    op_addr_nxt   = op_addr;
    op_size_nxt   = op_size;
    op_uns_nxt    = op_uns;
    op_m2r_nxt    = op_m2r;
    op_reg_we_nxt = op_reg_we;
    op_rd_nxt     = op_rd;
    req_nxt       = dmem_req;
    addr_nxt      = dmem_addr;
    dwe_nxt       = dmem_we;
    be_nxt        = dmem_be;
    dwdata_nxt    = dmem_wdata;
    wb_rd_nxt     = wb_rd;
    wb_data_nxt   = wb_data;
    wb_we_nxt     = 1'b0;
    done_nxt      = 1'b0;
    mis_nxt       = 1'b0;

    case (state)
      ST_IDLE: if (run) begin
        op_addr_nxt   = alu_result;
        op_size_nxt   = in_size;
        op_uns_nxt    = load_unsigned;
        op_m2r_nxt    = mem_to_reg;
        op_reg_we_nxt = reg_we;
        op_rd_nxt     = rd;
        if (trap) begin
          state_nxt   = ST_RESP;
          done_nxt    = 1'b1;
          mis_nxt     = 1'b1;
          wb_rd_nxt   = rd;
          wb_data_nxt = alu_result;
        end else if (mem_op) begin
          state_nxt  = ST_REQ;
          req_nxt    = 1'b1;
          addr_nxt   = {alu_result[31:2], 2'b00};
          dwe_nxt    = we;
          be_nxt     = byte_enables(in_size, alu_result[1:0]);
          dwdata_nxt = replicate_wdata(in_size, wdata);
        end else begin
          state_nxt   = ST_RESP;
          done_nxt    = 1'b1;
          wb_we_nxt   = reg_we;
          wb_rd_nxt   = rd;
          wb_data_nxt = alu_result;
        end
      end
      ST_REQ: if (dmem_ack) begin
        state_nxt   = ST_RESP;
        req_nxt     = 1'b0;
        done_nxt    = 1'b1;
        wb_we_nxt   = op_reg_we & ~dmem_we;
        wb_rd_nxt   = op_rd;
        wb_data_nxt = op_m2r ? load_data : op_addr;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state      <= ST_IDLE;
      op_addr    <= '0;
      op_size    <= SIZE_BYTE;
      op_uns     <= 1'b0;
      op_m2r     <= 1'b0;
      op_reg_we  <= 1'b0;
      op_rd      <= '0;
      dmem_req   <= 1'b0;
      dmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      done       <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_addr    <= op_addr_nxt;
      op_size    <= op_size_nxt;
      op_uns     <= op_uns_nxt;
      op_m2r     <= op_m2r_nxt;
      op_reg_we  <= op_reg_we_nxt;
      op_rd      <= op_rd_nxt;
      dmem_req   <= req_nxt;
      dmem_addr  <= addr_nxt;
      dmem_we    <= dwe_nxt;
      dmem_be    <= be_nxt;
      dmem_wdata <= dwdata_nxt;
      wb_we      <= wb_we_nxt;
      wb_rd      <= wb_rd_nxt;
      wb_data    <= wb_data_nxt;
      done       <= done_nxt;
      mis_q      <= mis_nxt;
    end
  end

endmodule
